// File: rtl/stopwatch_pkg.sv
// Shared types and BCD time arithmetic for the mm:ss.cc lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        SPLIT = 2'd3
    } sw_state_t;

    localparam int BCD_TIME_W = 24;
    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

    typedef struct packed {
        logic                  wrap;
        logic [BCD_TIME_W-1:0] value;
    } bcd_inc_t;

    // Digit order from LSB: c0 c1 s0 s1 m0 m1; the tens of seconds/minutes stop at 5.
    function automatic bcd_inc_t bcd_inc(input logic [BCD_TIME_W-1:0] t);
        bcd_inc_t   r;
        logic       carry;
        logic [3:0] d;
        logic [3:0] limit;
        r.value = t;
        carry   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d     = t[i*4 +: 4];
            limit = ((i == 3) || (i == 5)) ? DIGIT_MAX_5 : DIGIT_MAX_9;
            if (carry) begin
                if (d >= limit) begin
                    d     = 4'd0;
                    carry = 1'b1;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r.value[i*4 +: 4] = d;
        end
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_key_debounce.sv
// Active-low key synchroniser and debouncer emitting a one-cycle pulse on an accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // cnt holds how many consecutive samples already disagreed with level.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            level       <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                level       <= sync2;
                press_pulse <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_lap.sv
// mm:ss.cc stopwatch with split view, lap memory and sticky wrap flag, all on CLOCK_50.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_LAPS        = 4,
    localparam int SEL_W = (NUM_LAPS > 1) ? $clog2(NUM_LAPS) : 1,
    localparam int CNT_W = $clog2(NUM_LAPS + 1)
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [1:0]            KEY,
    input  logic [SEL_W-1:0]      LAP_SEL,
    output logic [BCD_TIME_W-1:0] DISP_BCD,
    output logic [BCD_TIME_W-1:0] LAP_DATA,
    output logic [CNT_W-1:0]      LAP_COUNT,
    output logic                  RUNNING,
    output logic                  SPLIT_VIEW,
    output logic                  OVF
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAPS_MAX = CNT_W'(NUM_LAPS);

    sw_state_t             state_q;
    sw_state_t             state_d;
    logic [BCD_TIME_W-1:0] time_q;
    logic [BCD_TIME_W-1:0] time_now;
    logic [BCD_TIME_W-1:0] split_q;
    logic [PRE_W-1:0]      presc_q;
    logic [CNT_W-1:0]      lap_cnt_q;
    logic                  ovf_q;
    logic [BCD_TIME_W-1:0] lap_mem [NUM_LAPS];
    logic [1:0]            key_pulse;
    logic [1:0]            unused_key_level;
    logic                  start_evt;
    logic                  lap_evt;
    logic                  counting;
    logic                  tick;
    logic                  capture;
    logic                  store;
    logic                  clear;
    bcd_inc_t              inc;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .key_n       (KEY[0]),
        .level       (unused_key_level[0]),
        .press_pulse (key_pulse[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .key_n       (KEY[1]),
        .level       (unused_key_level[1]),
        .press_pulse (key_pulse[1])
    );

    // time_now is the time after this cycle's tick; captures and lap writes use it.
    always_comb begin
        start_evt = key_pulse[0];
        lap_evt   = key_pulse[1] & ~key_pulse[0];
        counting  = (state_q == RUN) || (state_q == SPLIT);
        tick      = counting && (presc_q == PRE_LAST);
        inc       = bcd_inc(time_q);
        time_now  = tick ? inc.value : time_q;
        capture   = (state_q == RUN) && lap_evt;
        store     = capture && (lap_cnt_q < LAPS_MAX);
        clear     = (state_q == PAUSE) && lap_evt && !start_evt;
        state_d   = state_q;
        case (state_q)
            IDLE:  if (start_evt) state_d = RUN;
            RUN:   if (start_evt) state_d = PAUSE; else if (lap_evt) state_d = SPLIT;
            SPLIT: if (start_evt) state_d = PAUSE; else if (lap_evt) state_d = RUN;
            PAUSE: if (start_evt) state_d = RUN;   else if (lap_evt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            time_q    <= '0;
            split_q   <= '0;
            presc_q   <= '0;
            lap_cnt_q <= '0;
            ovf_q     <= 1'b0;
            DISP_BCD  <= '0;
            LAP_DATA  <= '0;
        end else begin
            state_q  <= state_d;
            DISP_BCD <= (state_q == SPLIT) ? split_q : time_q;
            LAP_DATA <= (int'(LAP_SEL) < int'(lap_cnt_q)) ? lap_mem[LAP_SEL] : '0;
            if (clear) begin
                time_q    <= '0;
                presc_q   <= '0;
                lap_cnt_q <= '0;
                ovf_q     <= 1'b0;
            end else begin
                time_q <= time_now;
                if (counting) presc_q <= tick ? '0 : presc_q + 1'b1;
                if (tick && inc.wrap) ovf_q <= 1'b1;
                if (capture) split_q <= time_now;
                if (store) lap_cnt_q <= lap_cnt_q + 1'b1;
            end
        end
    end

    // Lap memory has no reset; unwritten entries are masked by LAP_COUNT on read.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET && store) lap_mem[lap_cnt_q[SEL_W-1:0]] <= time_now;
    end

    assign RUNNING    = counting;
    assign SPLIT_VIEW = (state_q == SPLIT);
    assign LAP_COUNT  = lap_cnt_q;
    assign OVF        = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomised and directed bench for stopwatch_lap against a centisecond-level reference model.
module tb_stopwatch_lap;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int NUM_LAPS = 2;
    localparam int SEL_W    = 1;
    localparam int CNT_W    = 2;
    localparam int HOUR_CS  = 360000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       key = 2'b11;
    logic [SEL_W-1:0] lap_sel = '0;
    logic [23:0]      disp_bcd;
    logic [23:0]      lap_data;
    logic [CNT_W-1:0] lap_count;
    logic             running;
    logic             split_view;
    logic             ovf;

    stopwatch_lap #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .NUM_LAPS        (NUM_LAPS)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .KEY        (key),
        .LAP_SEL    (lap_sel),
        .DISP_BCD   (disp_bcd),
        .LAP_DATA   (lap_data),
        .LAP_COUNT  (lap_count),
        .RUNNING    (running),
        .SPLIT_VIEW (split_view),
        .OVF        (ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model (time kept as plain centiseconds) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_SPLIT} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_cs = 0;
    int          m_split = 0;
    int          m_run_cycles = 0;
    int          m_lapcnt = 0;
    bit          m_ovf = 1'b0;
    int          m_mem [NUM_LAPS];
    logic [23:0] m_disp = '0;
    logic [23:0] m_lapdata = '0;
    bit          m_lvl [2] = '{1'b1, 1'b1};
    bit          m_pulse [2] = '{1'b0, 1'b0};
    int          m_since [2] = '{0, 0};
    logic [1:0]  m_pipe [$] = '{2'b11, 2'b11};
    logic [1:0]  m_seen [$];

    function automatic logic [23:0] to_bcd(input int cs);
        int mins;
        int secs;
        int hund;
        mins = cs / 6000;
        secs = (cs / 100) % 60;
        hund = cs % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(hund / 10), 4'(hund % 10)};
    endfunction

    function automatic bit m_counting();
        return (m_mode == M_RUN) || (m_mode == M_SPLIT);
    endfunction

    function automatic bit m_tick_next();
        return m_counting() && ((m_run_cycles % TICK_DIV) == TICK_DIV - 1);
    endfunction

    task automatic model_step();
        logic [1:0] seen;
        bit         nxt_pulse [2];
        bit         tick;
        bit         start_p;
        bit         lap_p;
        if (rst) begin
            m_mode = M_IDLE;
            m_cs = 0;
            m_split = 0;
            m_run_cycles = 0;
            m_lapcnt = 0;
            m_ovf = 1'b0;
            m_disp = '0;
            m_lapdata = '0;
            m_lvl = '{1'b1, 1'b1};
            m_pulse = '{1'b0, 1'b0};
            m_since = '{0, 0};
            m_pipe = '{2'b11, 2'b11};
            m_seen.delete();
            return;
        end
        // Keys reach the debouncer two edges late; a level is accepted once the
        // last DEB samples since the previous acceptance all disagree with it.
        seen = m_pipe.pop_front();
        m_pipe.push_back(key);
        m_seen.push_back(seen);
        if (m_seen.size() > DEB) void'(m_seen.pop_front());
        for (int k = 0; k < 2; k++) begin
            bit all_differ;
            nxt_pulse[k] = 1'b0;
            m_since[k]++;
            all_differ = (m_since[k] >= DEB);
            foreach (m_seen[i]) if (m_seen[i][k] == m_lvl[k]) all_differ = 1'b0;
            if (all_differ) begin
                m_lvl[k] = !m_lvl[k];
                m_since[k] = 0;
                nxt_pulse[k] = !m_lvl[k];
            end
        end
        tick = m_tick_next();
        m_disp = (m_mode == M_SPLIT) ? to_bcd(m_split) : to_bcd(m_cs);
        m_lapdata = (int'(lap_sel) < m_lapcnt) ? to_bcd(m_mem[lap_sel]) : 24'h0;
        if (m_counting()) m_run_cycles++;
        if (tick) begin
            m_cs++;
            if (m_cs == HOUR_CS) begin
                m_cs = 0;
                m_ovf = 1'b1;
            end
        end
        start_p = m_pulse[0];
        lap_p = m_pulse[1] && !start_p;
        case (m_mode)
            M_IDLE: if (start_p) m_mode = M_RUN;
            M_RUN: begin
                if (start_p) m_mode = M_PAUSE;
                else if (lap_p) begin
                    m_mode = M_SPLIT;
                    m_split = m_cs;
                    if (m_lapcnt < NUM_LAPS) begin
                        m_mem[m_lapcnt] = m_cs;
                        m_lapcnt++;
                    end
                end
            end
            M_SPLIT: begin
                if (start_p) m_mode = M_PAUSE;
                else if (lap_p) m_mode = M_RUN;
            end
            M_PAUSE: begin
                if (start_p) m_mode = M_RUN;
                else if (lap_p) begin
                    m_mode = M_IDLE;
                    m_cs = 0;
                    m_run_cycles = 0;
                    m_lapcnt = 0;
                    m_ovf = 1'b0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_pulse = nxt_pulse;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("disp_bcd", disp_bcd, m_disp);
                check("lap_data", lap_data, m_lapdata);
                check("lap_count", 24'(lap_count), 24'(m_lapcnt));
                check("running", 24'(running), 24'(m_counting()));
                check("split_view", 24'(split_view), 24'(m_mode == M_SPLIT));
                check("ovf", 24'(ovf), 24'(m_ovf));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b1;
        key = 2'b11;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int k, input int hold, input int gap);
        key[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key[k] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int waited;
        int r;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_disp", disp_bcd, 24'h0);
        check("reset_lap_count", 24'(lap_count), 24'h0);

        // start key: pulse 5 edges after the raw edge, RUN on the 6th
        rst = 1'b0;
        key[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("start_latency_idle", 24'(running), 24'd0);
        @(negedge clk);
        check("start_latency_run", 24'(running), 24'd1);
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        repeat (396) @(negedge clk);
        check("disp_0_99", disp_bcd, 24'h000099);
        @(negedge clk);
        check("disp_1_00", disp_bcd, 24'h000100);

        // bouncing key never settles long enough
        do_reset();
        for (int i = 0; i < 10; i++) begin
            key[0] = i[0];
            repeat (2) @(negedge clk);
        end
        key[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_idle", 24'(running), 24'd0);
        check("bounce_disp", disp_bcd, 24'h0);

        // split at 00:00.37
        do_reset();
        lap_sel = 1'b0;
        key[0] = 1'b0;
        repeat (10) @(negedge clk);
        key[0] = 1'b1;
        repeat (140) @(negedge clk);
        key[1] = 1'b0;
        repeat (7) @(negedge clk);
        check("split_view_on", 24'(split_view), 24'd1);
        check("split_frozen", disp_bcd, 24'h000037);
        check("split_lap_count", 24'(lap_count), 24'd1);
        check("split_lap_data", lap_data, 24'h000037);
        repeat (3) @(negedge clk);
        key[1] = 1'b1;
        repeat (40) @(negedge clk);
        check("split_still_frozen", disp_bcd, 24'h000037);
        press(1, 8, 12);
        check("split_view_off", 24'(split_view), 24'd0);
        check("unsplit_lap_count", 24'(lap_count), 24'd1);

        // lap memory saturation
        press(1, 8, 12);
        press(1, 8, 12);
        lap_sel = 1'b1;
        press(1, 8, 12);
        check("sat_lap_count", 24'(lap_count), 24'd2);
        check("sat_split_view", 24'(split_view), 24'd1);

        // wrap from 59:59.99
        press(1, 8, 12);
        force dut.time_q = 24'h595999;
        m_cs = HOUR_CS - 1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_tick_next() && waited < 20);
        release dut.time_q;
        check("wrap_wait", 24'(waited < 20), 24'd1);
        @(negedge clk);
        check("wrap_ovf", 24'(ovf), 24'd1);
        check("wrap_last_disp", disp_bcd, 24'h595999);
        @(negedge clk);
        check("wrap_disp_zero", disp_bcd, 24'h0);
        press(0, 8, 12);
        press(1, 8, 12);
        check("clear_ovf", 24'(ovf), 24'd0);
        check("clear_lap_count", 24'(lap_count), 24'd0);
        check("clear_running", 24'(running), 24'd0);
        check("clear_disp", disp_bcd, 24'h0);

        // simultaneous keys, then reset mid-run
        press(0, 8, 12);
        repeat (20) @(negedge clk);
        key = 2'b00;
        repeat (8) @(negedge clk);
        key = 2'b11;
        repeat (12) @(negedge clk);
        check("both_paused", 24'(running), 24'd0);
        check("both_no_lap", 24'(lap_count), 24'd0);
        press(0, 8, 12);
        press(1, 8, 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_disp", disp_bcd, 24'h0);
        check("rst_lap_data", lap_data, 24'h0);
        check("rst_lap_count", 24'(lap_count), 24'd0);
        check("rst_running", 24'(running), 24'd0);
        check("rst_split", 24'(split_view), 24'd0);

        // random key traffic
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            lap_sel = 1'($urandom_range(0, 1));
            if (r < 3) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 45) begin
                press(0, int'($urandom_range(1, 12)), int'($urandom_range(0, 40)));
            end else if (r < 90) begin
                press(1, int'($urandom_range(1, 12)), int'($urandom_range(0, 40)));
            end else begin
                key = 2'b00;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                key = 2'b11;
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
